// File: rtl/rf_access_ctrl.sv
// Command-driven register-file initiator: single READ/WRITE plus whole-file DUMP/CLEAR,
// driving one rf read port and the rf write port, with a valid/ready response channel.
module rf_access_ctrl #(
  parameter bit          SKIP_X0   = 1'b1,
  parameter logic [31:0] CLR_VALUE = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [4:0]  o_rsp_addr,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_last,
  output logic        o_busy,
  output logic [4:0]  o_rs1_raddr,
  input  logic [31:0] i_rs1_rdata,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] LAST_IDX   = AW'(31);
  localparam logic [AW-1:0] FIRST_CLR  = AW'(1);
  localparam logic [AW-1:0] DUMP_START = SKIP_X0 ? AW'(1) : AW'(0);
  localparam logic [DW-1:0] CLR_COUNT  = DW'(31);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP,
    S_DMP_RD,
    S_DMP_RSP,
    S_CLR,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;

  // Handshake status is a pure decode of the state register.
  assign o_cmd_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);

  // Single sequencer: every port toward the rf and the response channel is registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_addr  <= '0;
      o_rsp_data  <= '0;
      o_rsp_last  <= 1'b0;
      o_rs1_raddr <= '0;
      o_rd_wen    <= 1'b0;
      o_rd_waddr  <= '0;
      o_rd_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            case (i_cmd_op)
              OP_WRITE: begin
                state      <= S_WR;
                o_rd_wen   <= 1'b1;
                o_rd_waddr <= i_cmd_addr;
                o_rd_wdata <= i_cmd_wdata;
              end
              OP_READ: begin
                state       <= S_RD;
                o_rs1_raddr <= i_cmd_addr;
              end
              OP_DUMP: begin
                state       <= S_DMP_RD;
                idx         <= DUMP_START;
                o_rs1_raddr <= DUMP_START;
              end
              default: begin
                state      <= S_CLR;
                idx        <= FIRST_CLR;
                o_rd_wen   <= 1'b1;
                o_rd_waddr <= FIRST_CLR;
                o_rd_wdata <= CLR_VALUE;
              end
            endcase
          end
        end

        S_WR: begin
          o_rd_wen <= 1'b0;
          state    <= S_IDLE;
        end

        S_RD: begin
          o_rsp_valid <= 1'b1;
          o_rsp_addr  <= o_rs1_raddr;
          o_rsp_data  <= i_rs1_rdata;
          o_rsp_last  <= 1'b1;
          state       <= S_RSP;
        end

        S_RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        S_DMP_RD: begin
          o_rsp_valid <= 1'b1;
          o_rsp_addr  <= idx;
          o_rsp_data  <= i_rs1_rdata;
          o_rsp_last  <= (idx == LAST_IDX);
          state       <= S_DMP_RSP;
        end

        // idx stops at x31, so the walk never wraps back to x0.
        S_DMP_RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
            end else begin
              idx         <= AW'(idx + AW'(1));
              o_rs1_raddr <= AW'(idx + AW'(1));
              state       <= S_DMP_RD;
            end
          end
        end

        S_CLR: begin
          if (idx == LAST_IDX) begin
            o_rd_wen    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_addr  <= '0;
            o_rsp_data  <= CLR_COUNT;
            o_rsp_last  <= 1'b1;
            state       <= S_DONE;
          end else begin
            idx        <= AW'(idx + AW'(1));
            o_rd_waddr <= AW'(idx + AW'(1));
          end
        end

        S_DONE: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
